// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters,
// with an optional zero-fill sweep of the whole RAM after reset.
module ram_arbiter #(
  parameter int BUS_WIDTH      = 8,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic                     we0,
  input  logic [ADDRESS_WIDTH-1:0] ad0,
  input  logic [BUS_WIDTH-1:0]     d0,
  output logic                     ack0,
  output logic [BUS_WIDTH-1:0]     q0,
  input  logic                     req1,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] ad1,
  input  logic [BUS_WIDTH-1:0]     d1,
  output logic                     ack1,
  output logic [BUS_WIDTH-1:0]     q1,
  output logic                     busy,
  output logic [ADDRESS_WIDTH-1:0] ram_ad,
  output logic                     ram_st,
  output logic [BUS_WIDTH-1:0]     ram_X,
  input  logic [BUS_WIDTH-1:0]     ram_O
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic                     last_q, last_d;   // 1 = port 1 was granted last
  logic [1:0]               ack_q, ack_d;
  logic [BUS_WIDTH-1:0]     q0_q, q0_d, q1_q, q1_d;
  logic                     elig0, elig1, gnt0, gnt1;

  // The ack cycle blocks the same port, forcing a one-cycle gap per port.
  assign elig0 = req0 & ~ack_q[0];
  assign elig1 = req1 & ~ack_q[1];
  assign gnt0  = (state_q == S_RUN) & elig0 & (~elig1 | last_q);
  assign gnt1  = (state_q == S_RUN) & elig1 & (~elig0 | ~last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ack_d   = 2'b00;
    q0_d    = q0_q;
    q1_d    = q1_q;
    ram_ad  = '0;
    ram_st  = 1'b0;
    ram_X   = '0;
    case (state_q)
      S_CLEAR: begin
        ram_ad = cnt_q;
        ram_st = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_RUN;
      end
      default: begin
        if (gnt0) begin
          ram_ad   = ad0;
          ram_st   = we0;
          ram_X    = d0;
          ack_d[0] = 1'b1;
          q0_d     = ram_O;
          last_d   = 1'b0;
        end else if (gnt1) begin
          ram_ad   = ad1;
          ram_st   = we1;
          ram_X    = d1;
          ack_d[1] = 1'b1;
          q1_d     = ram_O;
          last_d   = 1'b1;
        end
      end
    endcase
    // Reset aborts whatever access is in flight, including its RAM write.
    if (rst) ram_st = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      ack_q   <= 2'b00;
      q0_q    <= '0;
      q1_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
    end
  end

  assign ack0 = ack_q[0];
  assign ack1 = ack_q[1];
  assign q0   = q0_q;
  assign q1   = q1_q;
  assign busy = (state_q == S_CLEAR);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM attached.
module tb_ram_arbiter;
  localparam int BW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [AW-1:0] ad0 = '0, ad1 = '0;
  logic [BW-1:0] d0 = '0, d1 = '0;
  logic          ack0, ack1, busy, ram_st;
  logic [BW-1:0] q0, q1, ram_X, ram_O;
  logic [AW-1:0] ram_ad;

  logic          poke_en = 0;
  logic [AW-1:0] poke_ad = '0;
  logic [BW-1:0] poke_d = '0;
  logic [BW-1:0] mem [0:(1<<AW)-1];

  int n_vec = 0;
  int n_err = 0;

  ram_arbiter #(.BUS_WIDTH(BW), .ADDRESS_WIDTH(AW), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .ad0(ad0), .d0(d0), .ack0(ack0), .q0(q0),
    .req1(req1), .we1(we1), .ad1(ad1), .d1(d1), .ack1(ack1), .q1(q1),
    .busy(busy), .ram_ad(ram_ad), .ram_st(ram_st), .ram_X(ram_X), .ram_O(ram_O)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, write on rising edge; poke is a bench backdoor.
  assign ram_O = mem[ram_ad];
  always @(posedge clk) begin
    if (ram_st) mem[ram_ad] <= ram_X;
    else if (poke_en) mem[poke_ad] <= poke_d;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [BW-1:0] d);
    poke_en = 1; poke_ad = a; poke_d = d;
    step();
    poke_en = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 400) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset_clear();
    int n;
    rst = 1;
    poke(8'h05, 8'hAA);
    n_vec++;
    if (mem[5] !== 8'hAA) begin n_err++; $display("FAIL preload got=%h want=aa", mem[5]); end
    step();
    n_vec++;
    if (busy !== 1 || ram_ad !== 0 || ack0 !== 0 || ack1 !== 0 || q0 !== 0 || q1 !== 0) begin
      n_err++;
      $display("FAIL reset_state busy=%b ad=%h ack=%b%b q0=%h q1=%h want busy=1 ad=00 ack=00 q=00",
               busy, ram_ad, ack0, ack1, q0, q1);
    end
    rst = 0;
    wait_idle(n);
    n_vec++;
    if (n !== 256) begin n_err++; $display("FAIL sweep_len got=%0d want=256", n); end
    req0 = 1; we0 = 0; ad0 = 8'h05;
    step();
    req0 = 0;
    n_vec++;
    if (ack0 !== 1 || q0 !== 8'h00) begin
      n_err++; $display("FAIL cleared_read ack0=%b q0=%h want 1/00", ack0, q0);
    end
    step();
  endtask

  task automatic test_single_rw();
    req0 = 1; we0 = 1; ad0 = 8'h12; d0 = 8'h3C;
    #1;
    n_vec++;
    if (ram_st !== 1 || ram_ad !== 8'h12 || ram_X !== 8'h3C) begin
      n_err++; $display("FAIL wr_drive st=%b ad=%h X=%h want 1/12/3c", ram_st, ram_ad, ram_X);
    end
    step();
    req0 = 0; we0 = 0;
    n_vec++;
    if (ack0 !== 1 || q0 !== 8'h00) begin
      n_err++; $display("FAIL wr_ack ack0=%b q0=%h want 1/00", ack0, q0);
    end
    step();
    n_vec++;
    if (ack0 !== 0) begin n_err++; $display("FAIL ack_pulse ack0=%b want 0", ack0); end
    req0 = 1; we0 = 0; ad0 = 8'h12;
    step();
    req0 = 0;
    n_vec++;
    if (ack0 !== 1 || q0 !== 8'h3C) begin
      n_err++; $display("FAIL rd_back ack0=%b q0=%h want 1/3c", ack0, q0);
    end
    step();
  endtask

  task automatic test_req_during_clear();
    int n;
    bit early;
    rst = 1; step(); rst = 0;
    repeat (10) step();
    req1 = 1; we1 = 0; ad1 = 8'h05;
    early = 0; n = 0;
    while (busy && n < 400) begin
      if (ack1 !== 0) early = 1;
      n++;
      step();
    end
    n_vec++;
    if (early || n !== 246) begin
      n_err++; $display("FAIL clear_ignore early_ack=%0d cycles=%0d want 0/246", early, n);
    end
    n_vec++;
    if (ack1 !== 0 || ram_ad !== 8'h05 || ram_st !== 0) begin
      n_err++; $display("FAIL first_run_grant ack1=%b ad=%h st=%b want 0/05/0", ack1, ram_ad, ram_st);
    end
    step();
    req1 = 0;
    n_vec++;
    if (ack1 !== 1) begin n_err++; $display("FAIL clear_req_ack ack1=%b want 1", ack1); end
    step();
  endtask

  task automatic test_contention();
    int n;
    bit e0;
    rst = 1; step(); rst = 0;
    wait_idle(n);
    poke(8'h01, 8'h11);
    poke(8'h02, 8'h22);
    req0 = 1; we0 = 0; ad0 = 8'h01;
    req1 = 1; we1 = 0; ad1 = 8'h02;
    #1;
    n_vec++;
    if (ram_ad !== 8'h01 || ram_st !== 0) begin
      n_err++; $display("FAIL first_winner ad=%h st=%b want 01/0", ram_ad, ram_st);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      e0 = (k % 2 == 0);
      n_vec++;
      if (ack0 !== e0 || ack1 !== !e0) begin
        n_err++; $display("FAIL alternate k=%0d ack0=%b ack1=%b want %b/%b", k, ack0, ack1, e0, !e0);
      end
    end
    n_vec++;
    if (q0 !== 8'h11 || q1 !== 8'h22) begin
      n_err++; $display("FAIL contend_data q0=%h q1=%h want 11/22", q0, q1);
    end
    req0 = 0; req1 = 0;
    step();
  endtask

  task automatic test_cancel();
    // make port 0 the last grantee so port 1 wins the next contention
    req0 = 1; we0 = 0; ad0 = 8'h01;
    step();
    req0 = 0;
    step();
    req0 = 1; we0 = 1; ad0 = 8'h30; d0 = 8'h99;
    req1 = 1; we1 = 0; ad1 = 8'h02;
    #1;
    n_vec++;
    if (ram_ad !== 8'h02 || ram_st !== 0) begin
      n_err++; $display("FAIL cancel_winner ad=%h st=%b want 02/0", ram_ad, ram_st);
    end
    step();
    req0 = 0; req1 = 0; we0 = 0;
    n_vec++;
    if (ack1 !== 1 || ack0 !== 0) begin
      n_err++; $display("FAIL cancel_ack ack0=%b ack1=%b want 0/1", ack0, ack1);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (ack0 !== 0) begin n_err++; $display("FAIL cancel_noack k=%0d ack0=%b want 0", k, ack0); end
    end
    n_vec++;
    if (mem[8'h30] !== 8'h00) begin
      n_err++; $display("FAIL cancel_nowrite mem=%h want 00", mem[8'h30]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    rst = 1; step(); rst = 0;
    repeat (100) step();
    n_vec++;
    if (busy !== 1 || ram_ad !== 8'd100) begin
      n_err++; $display("FAIL sweep_100 busy=%b ad=%0d want 1/100", busy, ram_ad);
    end
    rst = 1; step(); rst = 0;
    n_vec++;
    if (busy !== 1 || ram_ad !== 8'h00) begin
      n_err++; $display("FAIL restart busy=%b ad=%h want 1/00", busy, ram_ad);
    end
    wait_idle(n);
    n_vec++;
    if (n !== 256) begin n_err++; $display("FAIL resweep_len got=%0d want=256", n); end
    req0 = 1; we0 = 1; ad0 = 8'h40; d0 = 8'h77;
    #1;
    n_vec++;
    if (ram_st !== 1) begin n_err++; $display("FAIL pre_abort st=%b want 1", ram_st); end
    rst = 1;
    #1;
    n_vec++;
    if (ram_st !== 0) begin n_err++; $display("FAIL abort_st st=%b want 0", ram_st); end
    step();
    rst = 0; req0 = 0; we0 = 0;
    n_vec++;
    if (ack0 !== 0 || busy !== 1) begin
      n_err++; $display("FAIL abort_ack ack0=%b busy=%b want 0/1", ack0, busy);
    end
    wait_idle(n);
    n_vec++;
    if (n !== 256 || mem[8'h40] !== 8'h00) begin
      n_err++; $display("FAIL abort_clear cycles=%0d mem=%h want 256/00", n, mem[8'h40]);
    end
  endtask

  initial begin
    test_reset_clear();
    test_single_rw();
    test_req_during_clear();
    test_contention();
    test_cancel();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
